// File: rtl/trig_dly_pkg.sv
// Shared types and sizing helpers for the trigger IDELAY tap update sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trig_dly_pkg;

  localparam int TRIG_LANES = 4;
  localparam int TAP_W      = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    WAIT_QUIET,
    LOAD,
    PULSE,
    SETTLE
  } state_e;

  // Counter width for a count of n cycles; a one-cycle count still gets one bit.
  function automatic int cnt_w(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/trig_quiet_det.sv
// Masked trigger-activity detector with quiet-run and timeout counters.
// Latency: quiet_ok/timeout are combinational from the counters and current inputs.
// Backpressure: none; counters run only while en_i is high and clear otherwise.
module trig_quiet_det
  import trig_dly_pkg::*;
#(
  parameter int QUIET_CYCLES  = 16,
  parameter int QUIET_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [TRIG_LANES-1:0] trigs_disable_i,
  input  logic [TRIG_LANES-1:0] trigs_i,
  output logic                  quiet_ok_o,
  output logic                  timeout_o
);

  localparam int QW = cnt_w(QUIET_CYCLES);
  localparam int TW = cnt_w(QUIET_TIMEOUT);
  localparam logic [QW-1:0] QLAST = QW'(QUIET_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(QUIET_TIMEOUT - 1);

  logic          active;
  logic [QW-1:0] quiet_cnt_q, quiet_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Disabled lanes are masked off, so an all-disabled array is always quiet.
  assign active = |(trigs_i & ~trigs_disable_i);

  always_comb begin
    quiet_cnt_d = '0;
    tmo_cnt_d   = '0;
    if (en_i) begin
      quiet_cnt_d = active ? '0 : quiet_cnt_q + 1'b1;
      tmo_cnt_d   = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      quiet_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      quiet_cnt_q <= quiet_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign quiet_ok_o = en_i && !active && (quiet_cnt_q == QLAST);
  assign timeout_o  = en_i && (tmo_cnt_q == TLAST);

endmodule

// File: rtl/trig_idelay_cfg_ctrl.sv
// Shadows per-lane IDELAY taps and commits them with update_delays only when IDELAYCTRL is ready and triggers are quiet.
// Latency: apply to done is 3+QUIET+PULSE+SETTLE cycles minimum; TRIG_DLY_AUTO_APPLY_EN makes shadow writes also request an apply.
// Backpressure: applies while busy collapse into one pending request served after a single IDLE cycle.
module trig_idelay_cfg_ctrl
  import trig_dly_pkg::*;
#(
  parameter int QUIET_CYCLES  = 16,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int QUIET_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  idelayctrl_rdy_i,
  input  logic [TRIG_LANES-1:0] trigs_disable_i,
  input  logic [TRIG_LANES-1:0] trigs_in_delayed_i,
  input  logic                  cfg_wr_en_i,
  input  logic [1:0]            cfg_wr_sel_i,
  input  logic [TAP_W-1:0]      cfg_wr_dly_i,
  input  logic                  cfg_apply_i,
  output logic                  cfg_busy_o,
  output logic                  cfg_done_o,
  output logic                  cfg_err_o,
  output logic [TAP_W-1:0]      trig0_dly_o,
  output logic [TAP_W-1:0]      trig1_dly_o,
  output logic [TAP_W-1:0]      trig2_dly_o,
  output logic [TAP_W-1:0]      trig3_dly_o,
  output logic                  update_delays_o
);

  localparam int PW = cnt_w(PULSE_CYCLES);
  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic            rdy_meta_q, rdy_sync_q;
  logic            pending_q, pending_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [PW-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic            load_taps;
  logic            apply_req;
  logic            quiet_ok, quiet_tmo;
  logic [TAP_W-1:0] shadow_q [TRIG_LANES];
  logic [TAP_W-1:0] taps_q   [TRIG_LANES];

`ifdef TRIG_DLY_AUTO_APPLY_EN
  assign apply_req = cfg_apply_i | cfg_wr_en_i;
`else
  assign apply_req = cfg_apply_i;
`endif

  trig_quiet_det #(
    .QUIET_CYCLES  (QUIET_CYCLES),
    .QUIET_TIMEOUT (QUIET_TIMEOUT)
  ) u_quiet_det (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .en_i            (state_q == WAIT_QUIET),
    .trigs_disable_i (trigs_disable_i),
    .trigs_i         (trigs_in_delayed_i),
    .quiet_ok_o      (quiet_ok),
    .timeout_o       (quiet_tmo)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
    end else begin
      rdy_meta_q <= idelayctrl_rdy_i;
      rdy_sync_q <= rdy_meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    pulse_cnt_d  = '0;
    settle_cnt_d = '0;
    load_taps    = 1'b0;

    // Any apply seen outside IDLE, including the last SETTLE cycle, is held for the next round.
    if (state_q != IDLE && apply_req) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (apply_req || pending_q) begin
          state_d   = WAIT_RDY;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          pending_d = 1'b0;
        end
      end
      WAIT_RDY: begin
        if (rdy_sync_q) begin
          state_d = WAIT_QUIET;
        end
      end
      WAIT_QUIET: begin
        if (quiet_ok) begin
          state_d   = LOAD;
          load_taps = 1'b1;
        end else if (quiet_tmo) begin
          state_d   = LOAD;
          load_taps = 1'b1;
          err_d     = 1'b1;
        end
      end
      LOAD: begin
        state_d = PULSE;
      end
      PULSE: begin
        pulse_cnt_d = pulse_cnt_q + 1'b1;
        if (pulse_cnt_q == PLAST) begin
          state_d     = SETTLE;
          pulse_cnt_d = '0;
        end
      end
      SETTLE: begin
        settle_cnt_d = settle_cnt_q + 1'b1;
        if (settle_cnt_q == SLAST) begin
          state_d      = IDLE;
          settle_cnt_d = '0;
          done_d       = 1'b1;
          busy_d       = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pulse_cnt_q  <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      pulse_cnt_q  <= pulse_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Taps latch on entry to LOAD so they are stable a full cycle before the strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < TRIG_LANES; i++) begin
        shadow_q[i] <= '0;
        taps_q[i]   <= '0;
      end
    end else begin
      if (cfg_wr_en_i) begin
        shadow_q[cfg_wr_sel_i] <= cfg_wr_dly_i;
      end
      if (load_taps) begin
        for (int i = 0; i < TRIG_LANES; i++) begin
          taps_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign cfg_busy_o      = busy_q;
  assign cfg_done_o      = done_q;
  assign cfg_err_o       = err_q;
  assign update_delays_o = (state_q == PULSE);
  assign trig0_dly_o     = taps_q[0];
  assign trig1_dly_o     = taps_q[1];
  assign trig2_dly_o     = taps_q[2];
  assign trig3_dly_o     = taps_q[3];

endmodule

// File: tb/tb_trig_idelay_cfg_ctrl.sv
// Bench for trig_idelay_cfg_ctrl: directed and random stimulus tables, outputs recorded per cycle
// and compared against a timeline model built from the sequencing rules.
module tb_trig_idelay_cfg_ctrl;

  localparam int MAXN   = 2400;
  localparam int QUIET  = 16;
  localparam int PULSE  = 2;
  localparam int SETTLE = 8;
  localparam int TMO    = 1024;
`ifdef TRIG_DLY_AUTO_APPLY_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rdy = 1'b0;
  logic [3:0] dis = '0;
  logic [3:0] trig = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [4:0] wr_dly = '0;
  logic       apply = 1'b0;
  logic       busy, done, err, upd;
  logic [4:0] t0, t1, t2, t3;

  int n_cmp = 0;
  int n_mis = 0;

  logic       apply_a [MAXN];
  logic       wr_en_a [MAXN];
  logic [1:0] wr_sel_a[MAXN];
  logic [4:0] wr_dly_a[MAXN];
  logic       rdy_a   [MAXN];
  logic [3:0] trig_a  [MAXN];
  logic [3:0] dis_a   [MAXN];
  logic [23:0] obs_a  [MAXN];
  logic       e_busy[MAXN], e_done[MAXN], e_err[MAXN], e_upd[MAXN];
  logic [19:0] e_taps[MAXN];

  trig_idelay_cfg_ctrl #(
    .QUIET_CYCLES (QUIET), .PULSE_CYCLES (PULSE),
    .SETTLE_CYCLES(SETTLE), .QUIET_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .idelayctrl_rdy_i(rdy),
    .trigs_disable_i(dis), .trigs_in_delayed_i(trig),
    .cfg_wr_en_i(wr_en), .cfg_wr_sel_i(wr_sel), .cfg_wr_dly_i(wr_dly),
    .cfg_apply_i(apply),
    .cfg_busy_o(busy), .cfg_done_o(done), .cfg_err_o(err),
    .trig0_dly_o(t0), .trig1_dly_o(t1), .trig2_dly_o(t2), .trig3_dly_o(t3),
    .update_delays_o(upd)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] out_vec();
    return {busy, done, err, upd, t3, t2, t1, t0};
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < MAXN; c++) begin
      apply_a[c] = 0; wr_en_a[c] = 0; wr_sel_a[c] = '0; wr_dly_a[c] = '0;
      rdy_a[c] = 0; trig_a[c] = '0; dis_a[c] = '0; obs_a[c] = '0;
    end
  endtask

  task automatic run_scn(input int n);
    rst_n = 0; rdy = 0; dis = '0; trig = '0; wr_en = 0; wr_sel = '0; wr_dly = '0; apply = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      apply = apply_a[c]; wr_en = wr_en_a[c]; wr_sel = wr_sel_a[c]; wr_dly = wr_dly_a[c];
      rdy = rdy_a[c]; trig = trig_a[c]; dis = dis_a[c];
      @(negedge clk);
      obs_a[c] = out_vec();
    end
  endtask

  function automatic logic app_eff(input int c);
    return apply_a[c] | (AUTO & wr_en_a[c]);
  endfunction

  function automatic logic act(input int c);
    return |(trig_a[c] & ~dis_a[c]);
  endfunction

  // Shadow contents formed by every write strictly before cycle upto.
  function automatic logic [19:0] taps_at(input int upto);
    logic [4:0] s [4];
    for (int i = 0; i < 4; i++) s[i] = '0;
    for (int c = 0; c < upto; c++) if (wr_en_a[c]) s[wr_sel_a[c]] = wr_dly_a[c];
    return {s[3], s[2], s[1], s[0]};
  endfunction

  // Timeline model: accept cycle a, ready cycle r (sync'd rdy = input two cycles earlier),
  // quiet/timeout exit cycle e, then LOAD e+1, strobe e+2.., done e+2+PULSE+SETTLE.
  task automatic model_check(input string nm, input int n);
    int pos, a, r, e, run, dcyc;
    bit pend, tmo;
    logic [19:0] tv;
    for (int c = 0; c < n; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0; e_upd[c] = 0; e_taps[c] = '0;
    end
    pos = 0; pend = 0;
    while (pos < n) begin
      a = -1;
      if (pend) a = pos;
      else for (int c = pos; c < n; c++) if (app_eff(c)) begin a = c; break; end
      if (a < 0) break;
      for (int c = a + 1; c < n; c++) e_err[c] = 0;
      r = -1;
      for (int c = a + 1; c < n; c++) if (c >= 2 && rdy_a[c-2]) begin r = c; break; end
      e = -1; tmo = 0; run = 0;
      if (r >= 0) begin
        for (int c = r + 1; c < n; c++) begin
          run = act(c) ? 0 : run + 1;
          if (run >= QUIET) begin e = c; break; end
          if (c - (r + 1) == TMO - 1) begin e = c; tmo = 1; break; end
        end
      end
      if (e < 0) begin
        for (int c = a + 1; c < n; c++) e_busy[c] = 1;
        break;
      end
      dcyc = e + 2 + PULSE + SETTLE;
      for (int c = a + 1; c < dcyc && c < n; c++) e_busy[c] = 1;
      if (dcyc < n) e_done[dcyc] = 1;
      for (int c = e + 2; c < e + 2 + PULSE && c < n; c++) e_upd[c] = 1;
      tv = taps_at(e);
      for (int c = e + 1; c < n; c++) begin e_taps[c] = tv; e_err[c] = tmo; end
      pend = 0;
      for (int c = a + 1; c < dcyc && c < n; c++) if (app_eff(c)) pend = 1;
      pos = dcyc;
    end
    for (int c = 0; c < n; c++)
      check_val($sformatf("%s@%0d", nm, c), 32'(obs_a[c]),
                32'({e_busy[c], e_done[c], e_err[c], e_upd[c], e_taps[c]}));
  endtask

  function automatic int first_bit(input int b, input int n);
    for (int c = 0; c < n; c++) if (obs_a[c][b]) return c;
    return -1;
  endfunction

  function automatic int count_bit(input int b, input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (obs_a[c][b]) k++;
    return k;
  endfunction

  initial begin
    int p;
    logic rl;
    logic [3:0] dl;

    // Basic: lane2=17, apply at 4, rdy high, quiet lanes -> done at 33.
    clear_stim();
    for (int c = 0; c < MAXN; c++) rdy_a[c] = 1;
    wr_en_a[1] = 1; wr_sel_a[1] = 2; wr_dly_a[1] = 17; apply_a[4] = 1;
    run_scn(60);
    check_val("reset_state", 32'(obs_a[0]), 0);
    check_val("latency", 32'(first_bit(22, 60) - 4), 29);
    check_val("tap2_at_load", 32'(obs_a[22][14:10]), 17);
    check_val("tap2_before_load", 32'(obs_a[21][14:10]), 0);
    check_val("pulse_len", 32'(count_bit(20, 60)), 2);
    model_check("basic", 60);

    // Async reset mid-PULSE: cycle 23 is the first strobe cycle.
    run_scn(24);
    check_val("pre_rst_upd", 32'(obs_a[23][20]), 1);
    #1 rst_n = 0;
    #1 check_val("async_rst", 32'(out_vec()), 0);

    // Lane0 toggling every 10 cycles; last activity at 59 -> LOAD at 76.
    clear_stim();
    for (int c = 0; c < MAXN; c++) begin
      rdy_a[c] = 1;
      trig_a[c] = (c >= 5 && c < 65 && ((c / 10) % 2) == 1) ? 4'b0001 : 4'b0000;
    end
    wr_en_a[1] = 1; wr_sel_a[1] = 0; wr_dly_a[1] = 9; apply_a[4] = 1;
    run_scn(120);
    check_val("toggle_no_early_load", 32'(obs_a[75][4:0]), 0);
    check_val("toggle_load", 32'(obs_a[76][4:0]), 9);
    model_check("toggle", 120);

    // Lane1 stuck high -> timeout after 1024 quiet-wait cycles, then a clean apply clears err.
    clear_stim();
    for (int c = 0; c < MAXN; c++) begin
      rdy_a[c] = 1;
      trig_a[c] = (c < 1090) ? 4'b0010 : 4'b0000;
    end
    wr_en_a[2] = 1; wr_sel_a[2] = 1; wr_dly_a[2] = 5;
    apply_a[4] = 1; apply_a[1100] = 1;
    run_scn(1200);
    check_val("tmo_err_pre", 32'(obs_a[1029][21]), 0);
    check_val("tmo_err_set", 32'(obs_a[1030][21]), 1);
    check_val("tmo_forced_tap", 32'(obs_a[1030][9:5]), 5);
    check_val("tmo_done", 32'(obs_a[1041][22]), 1);
    check_val("err_cleared", 32'(obs_a[1101][21]), 0);
    model_check("timeout", 1200);

    // Two applies during PULSE collapse into one follow-on sequence after one IDLE cycle.
    clear_stim();
    for (int c = 0; c < MAXN; c++) rdy_a[c] = 1;
    apply_a[4] = 1; apply_a[23] = 1; apply_a[24] = 1;
    run_scn(100);
    check_val("b2b_done_cnt", 32'(count_bit(22, 100)), 2);
    check_val("b2b_upd_cnt", 32'(count_bit(20, 100)), 4);
    check_val("b2b_idle_gap", 32'(obs_a[33][23]), 0);
    check_val("b2b_restart", 32'(obs_a[34][23]), 1);
    model_check("b2b", 100);

    // rdy low at apply; raised at 40 and dropped again at 50 (ignored once past WAIT_RDY).
    clear_stim();
    for (int c = 0; c < MAXN; c++) rdy_a[c] = (c >= 40 && c < 50);
    apply_a[4] = 1;
    run_scn(100);
    check_val("rdy_wait_busy", 32'(obs_a[41][23]), 1);
    check_val("rdy_done", 32'(obs_a[70][22]), 1);
    model_check("rdy", 100);

`ifdef TRIG_DLY_AUTO_APPLY_EN
    clear_stim();
    for (int c = 0; c < MAXN; c++) rdy_a[c] = 1;
    wr_en_a[3] = 1; wr_sel_a[3] = 3; wr_dly_a[3] = 31;
    run_scn(60);
    check_val("auto_tap3", 32'(obs_a[50][19:15]), 31);
    check_val("auto_done_cnt", 32'(count_bit(22, 60)), 1);
    model_check("auto", 60);
`endif

    // Random traffic; the last run is heavy activity with alternating all-disabled windows.
    for (int s = 0; s < 5; s++) begin
      int n;
      clear_stim();
      n  = (s == 4) ? 2000 : 600;
      p  = (s == 4) ? 1 : int'($urandom_range(8, 40));
      rl = 1'b1;
      dl = '0;
      for (int c = 0; c < n; c++) begin
        wr_en_a[c]  = ($urandom_range(0, 7) == 0);
        wr_sel_a[c] = 2'($urandom_range(0, 3));
        wr_dly_a[c] = 5'($urandom_range(0, 31));
        apply_a[c]  = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 29) == 0) rl = ~rl;
        rdy_a[c]  = rl;
        trig_a[c] = ($urandom_range(0, p) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        if (s == 4) dl = (((c / 700) % 2) == 1) ? 4'hF : 4'h0;
        else if ($urandom_range(0, 99) == 0) dl = 4'($urandom_range(0, 15));
        dis_a[c] = dl;
      end
      run_scn(n);
      model_check($sformatf("rand%0d", s), n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
